// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-wide data memory.
// Handles RV32I byte/halfword/word loads and stores; sub-word stores are
// done as a read-modify-write. Each request ends in a one-cycle response pulse.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] read_address,
    output logic [31:0] Write_data,
    input  logic [31:0] MemData_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        req_err;
    logic        bad_funct3;
    logic        misaligned;
    logic        out_of_range;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
    logic [4:0]  lane_shift;
    logic [31:0] lane_word;
    logic [31:0] lane_mask;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Validate the incoming request (funct3, alignment, word-index range)
    always_comb begin
        case (req_funct3)
            3'd0, 3'd1, 3'd2: bad_funct3 = 1'b0;
            3'd4, 3'd5:       bad_funct3 = req_write;
            default:          bad_funct3 = 1'b1;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
        req_err      = bad_funct3 || misaligned || out_of_range;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and memory/handshake strobes
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    accept = 1'b1;
                    if (req_err)                 next_state = RESP;
                    else if (!req_write)         next_state = LOAD;
                    else if (req_funct3 == 3'd2) next_state = STORE;
                    else                         next_state = RMW_RD;
                end
            end
            LOAD: begin
                MemRead    = 1'b1;
                next_state = RESP;
            end
            STORE: begin
                MemWrite   = 1'b1;
                next_state = RESP;
            end
            RMW_RD: begin
                MemRead    = 1'b1;
                next_state = RMW_WR;
            end
            RMW_WR: begin
                MemWrite   = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    // Halfword accesses are aligned, so shifting by byte offset * 8 also
    // selects the right halfword.
    always_comb begin
        lane_shift = {lat_off, 3'b000};
        lane_word  = MemData_out >> lane_shift;
        case (lat_funct3)
            3'd0:    load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            3'd1:    load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'd4:    load_val = {24'h000000, lane_word[7:0]};
            3'd5:    load_val = {16'h0000, lane_word[15:0]};
            default: load_val = MemData_out;
        endcase
        lane_mask = (lat_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
        merged    = (MemData_out & ~lane_mask) | ((lat_wdata << lane_shift) & lane_mask);
    end

    // Request latches, memory address/data and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_funct3   <= '0;
            lat_off      <= '0;
            lat_wdata    <= '0;
            read_address <= '0;
            Write_data   <= '0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
        end else begin
            if (accept) begin
                lat_funct3   <= req_funct3;
                lat_off      <= req_addr[1:0];
                lat_wdata    <= req_wdata;
                read_address <= {2'b00, req_addr[31:2]};
                resp_error   <= req_err;
                resp_rdata   <= '0;
                if (!req_err && req_write && (req_funct3 == 3'd2))
                    Write_data <= req_wdata;
            end
            case (state)
                LOAD:   resp_rdata <= load_val;
                RMW_RD: Write_data <= merged;
                RESP: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a word-wide memory model.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] read_address;
    logic [31:0] Write_data;
    logic [31:0] MemData_out;

    logic [31:0] mem [0:DEPTH-1];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    logic        overlap_seen = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] wd;
        logic        rd_seen;
        logic        wr_seen;
    } vec_t;

    vec_t vecs [18];

    load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .MemRead(MemRead), .MemWrite(MemWrite), .read_address(read_address),
        .Write_data(Write_data), .MemData_out(MemData_out)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at posedge
    assign MemData_out = (read_address < DEPTH) ? mem[read_address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite && (read_address < DEPTH)) mem[read_address[5:0]] <= Write_data;
        else if (pre_en) mem[pre_idx] <= pre_val;
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite) overlap_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Issue one request from IDLE and observe it until the response (bounded)
    task automatic run_req(input vec_t v, output int lat, output logic [31:0] rdata,
                           output logic err, output logic rd, output logic wr,
                           output logic [31:0] ra, output logic [31:0] wd);
        lat = 0; rdata = 32'hDEAD_0000; err = 1'bx; rd = 1'b0; wr = 1'b0;
        ra = 32'hFFFF_FFFF; wd = 32'hFFFF_FFFF;
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (MemRead)  rd = 1'b1;
            if (MemWrite) begin wr = 1'b1; wd = Write_data; end
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_error; ra = read_address;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata, ra, wd;
        logic        err, rd, wr;
        int          seen_wr, seen_resp;

        vecs[0]  = '{1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 2, 32'd91,        32'h0,         1'b1, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 32'h05, 32'h80,        1'b0, 3, 32'h0,         32'h0000_8054, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 3'd0, 32'h05, 32'h0,         1'b0, 2, 32'hFFFF_FF80, 32'h0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd4, 32'h05, 32'h0,         1'b0, 2, 32'h0000_0080, 32'h0,         1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 32'h0A, 32'h1234_BEEF, 1'b0, 3, 32'h0,         32'hBEEF_0017, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 3'd1, 32'h0A, 32'h0,         1'b0, 2, 32'hFFFF_BEEF, 32'h0,         1'b1, 1'b0};
        vecs[6]  = '{1'b0, 3'd5, 32'h0A, 32'h0,         1'b0, 2, 32'h0000_BEEF, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'h0B, 32'h0,         1'b0, 2, 32'hFFFF_FFBE, 32'h0,         1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'd4, 32'h08, 32'h0,         1'b0, 2, 32'h0000_0017, 32'h0,         1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'd2, 32'h06, 32'h0,         1'b1, 1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 32'h100, 32'h55,       1'b1, 1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'd3, 32'h00, 32'h0,         1'b1, 1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'd1, 32'h03, 32'h1,         1'b1, 1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[13] = '{1'b1, 3'd4, 32'h00, 32'h1,         1'b1, 1, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[14] = '{1'b1, 3'd2, 32'hFC, 32'hDEAD_BEEF, 1'b0, 2, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 3'd2, 32'hFC, 32'h0,         1'b0, 2, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0};
        vecs[16] = '{1'b0, 3'd5, 32'h0E, 32'h0,         1'b0, 2, 32'h0000_8001, 32'h0,         1'b1, 1'b0};
        vecs[17] = '{1'b0, 3'd1, 32'h0C, 32'h0,         1'b0, 2, 32'h0000_7FFF, 32'h0,         1'b1, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;

        // Reset state
        #12;
        check("reset_outputs",
              {31'b0, MemRead} | {31'b0, MemWrite} | read_address | Write_data |
              {31'b0, resp_valid} | resp_rdata | {31'b0, resp_error}, 32'h0);
        check("reset_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < int'(DEPTH); i++) preload(6'(i), 32'h0);
        preload(6'd1, 32'h54);
        preload(6'd2, 32'h17);
        preload(6'd3, 32'h8001_7FFF);
        preload(6'd4, 32'd91);

        // Table-driven vectors
        foreach (vecs[i]) begin
            check($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'h1);
            run_req(vecs[i], lat, rdata, err, rd, wr, ra, wd);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_error", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d_memread", i), {31'b0, rd}, {31'b0, vecs[i].rd_seen});
            check($sformatf("v%0d_memwrite", i), {31'b0, wr}, {31'b0, vecs[i].wr_seen});
            check($sformatf("v%0d_addr", i), ra, vecs[i].addr >> 2);
            if (vecs[i].wr_seen)
                check($sformatf("v%0d_wdata", i), wd, vecs[i].wd);
        end

        // Reset during RMW_RD aborts the store
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h05; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_rd_read", {31'b0, MemRead}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs",
              {31'b0, MemRead} | {31'b0, MemWrite} | read_address | Write_data |
              {31'b0, resp_valid} | resp_rdata | {31'b0, resp_error}, 32'h0);
        check("midreset_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        seen_wr = 0; seen_resp = 0;
        if (MemWrite) seen_wr++;
        if (resp_valid) seen_resp++;
        reset = 1'b0;
        #1;
        check("ready_after_release", {31'b0, req_ready}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (MemWrite) seen_wr++;
            if (resp_valid) seen_resp++;
        end
        check("abort_no_write", 32'(seen_wr), 32'h0);
        check("abort_no_resp", 32'(seen_resp), 32'h0);
        check("abort_mem_kept", mem[1], 32'h0000_8054);

        // Back-to-back with req_valid held high
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h00; req_wdata = 32'd7;
        @(posedge clk); #1;
        check("b2b_store_cycle", {30'b0, MemWrite, req_ready}, 32'h2);
        req_write = 1'b0;
        @(posedge clk); #1;
        check("b2b_resp_cycle", {29'b0, resp_valid, req_ready, MemRead}, 32'h4);
        @(posedge clk); #1;
        check("b2b_idle_cycle", {29'b0, resp_valid, req_ready, MemRead}, 32'h2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_load_cycle", {31'b0, MemRead}, 32'h1);
        @(posedge clk); #1;
        check("b2b_load_resp", {31'b0, resp_valid}, 32'h1);
        check("b2b_load_data", resp_rdata, 32'd7);
        @(posedge clk); #1;
        check("b2b_back_idle", {30'b0, req_ready, MemRead}, 32'h2);

        check("strobes_never_overlap", {31'b0, overlap_seen}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
